// File: rtl/exec_pkg.sv
// Shared definitions for the RV32I execute stage.
//   ALU_*      : 3-bit ALU opcodes carried on ALUControlE
//   fwd_sel_e  : operand source select for the forwarding muxes
//   fwd_select : turns MEM/WB hazard hits into a select, MEM winning
package exec_pkg;

  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SUB = 3'b001;
  localparam logic [2:0] ALU_AND = 3'b010;
  localparam logic [2:0] ALU_OR  = 3'b011;
  localparam logic [2:0] ALU_SLT = 3'b101;

  typedef enum logic [1:0] {
    FWD_RF,
    FWD_WB,
    FWD_MEM
  } fwd_sel_e;

  // The MEM stage holds the younger result, so it beats WB.
  function automatic fwd_sel_e fwd_select(input logic mem_hit, input logic wb_hit);
    if (mem_hit)     return FWD_MEM;
    else if (wb_hit) return FWD_WB;
    else             return FWD_RF;
  endfunction

endpackage

// File: rtl/alu.sv
// Combinational ALU for the execute stage.
//   SrcA, SrcB  : operands
//   ALUControl  : opcode (add, sub, and, or, signed slt; others give 0)
//   Result      : result, modulo 2^DATA_W
//   Zero        : Result == 0, used for beq
module alu
  import exec_pkg::*;
#(
  parameter int DATA_W = 32
) (
  input  logic [DATA_W-1:0] SrcA,
  input  logic [DATA_W-1:0] SrcB,
  input  logic [2:0]        ALUControl,
  output logic [DATA_W-1:0] Result,
  output logic              Zero
);

  logic slt;

  assign slt = ($signed(SrcA) < $signed(SrcB));

  always_comb begin
    Result = '0;
    case (ALUControl)
      ALU_ADD: Result = SrcA + SrcB;
      ALU_SUB: Result = SrcA - SrcB;
      ALU_AND: Result = SrcA & SrcB;
      ALU_OR:  Result = SrcA | SrcB;
      ALU_SLT: Result = {{(DATA_W-1){1'b0}}, slt};
      default: Result = '0;
    endcase
  end

  assign Zero = (Result == '0);

endmodule

// File: rtl/execute_cycle.sv
// Execute stage of the 5-stage RV32I pipeline.
// Takes the ID/EX register outputs, forwards operands from MEM/WB, runs the
// ALU, resolves beq and computes the branch target, and holds the EX/MEM
// pipeline register.
//   Inputs : clk, rst (async, active-low), decode controls, RD1/RD2/imm,
//            RS1/RS2/RD indices, PCE/PCPlus4E, WB forwarding source
//   Outputs: PCSrcE/PCTargetE (combinational), EX/MEM register (*M)
// Build option: define EXEC_FWD_EN to include the forwarding muxes; without
// it the operands come straight from the register file values.
module execute_cycle
  import exec_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int REG_AW = 5
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              RegWriteE,
  input  logic              ALUSrcE,
  input  logic              MemWriteE,
  input  logic              ResultSrcE,
  input  logic              BranchE,
  input  logic [2:0]        ALUControlE,
  input  logic [DATA_W-1:0] RD1_E,
  input  logic [DATA_W-1:0] RD2_E,
  input  logic [DATA_W-1:0] Imm_Ext_E,
  input  logic [REG_AW-1:0] RS1_E,
  input  logic [REG_AW-1:0] RS2_E,
  input  logic [REG_AW-1:0] RD_E,
  input  logic [DATA_W-1:0] PCE,
  input  logic [DATA_W-1:0] PCPlus4E,
  input  logic              RegWriteW,
  input  logic [REG_AW-1:0] RDW,
  input  logic [DATA_W-1:0] ResultW,
  output logic              PCSrcE,
  output logic [DATA_W-1:0] PCTargetE,
  output logic              RegWriteM,
  output logic              MemWriteM,
  output logic              ResultSrcM,
  output logic [REG_AW-1:0] RD_M,
  output logic [DATA_W-1:0] ALUResultM,
  output logic [DATA_W-1:0] WriteDataM,
  output logic [DATA_W-1:0] PCPlus4M
);

  logic [DATA_W-1:0] src_a;
  logic [DATA_W-1:0] src_b;
  logic [DATA_W-1:0] write_data_e;
  logic [DATA_W-1:0] alu_result_e;
  logic              zero_e;

  logic              reg_write_d,  reg_write_q;
  logic              mem_write_d,  mem_write_q;
  logic              result_src_d, result_src_q;
  logic [REG_AW-1:0] rd_d,         rd_q;
  logic [DATA_W-1:0] alu_result_d, alu_result_q;
  logic [DATA_W-1:0] write_data_d, write_data_q;
  logic [DATA_W-1:0] pc_plus4_d,   pc_plus4_q;

`ifdef EXEC_FWD_EN
  fwd_sel_e fwd_a_sel;
  fwd_sel_e fwd_b_sel;

  // x0 is hardwired zero, so a pending write to it must never be forwarded.
  always_comb begin
    fwd_a_sel = fwd_select(reg_write_q && (rd_q != '0) && (rd_q == RS1_E),
                           RegWriteW && (RDW != '0) && (RDW == RS1_E));
    fwd_b_sel = fwd_select(reg_write_q && (rd_q != '0) && (rd_q == RS2_E),
                           RegWriteW && (RDW != '0) && (RDW == RS2_E));
  end

  always_comb begin
    src_a = RD1_E;
    case (fwd_a_sel)
      FWD_MEM: src_a = alu_result_q;
      FWD_WB:  src_a = ResultW;
      default: src_a = RD1_E;
    endcase
    write_data_e = RD2_E;
    case (fwd_b_sel)
      FWD_MEM: write_data_e = alu_result_q;
      FWD_WB:  write_data_e = ResultW;
      default: write_data_e = RD2_E;
    endcase
  end
`else
  // Without forwarding the WB inputs exist only on the port list.
  logic unused_fwd;
  assign unused_fwd   = ^{RegWriteW, RDW, ResultW};
  assign src_a        = RD1_E;
  assign write_data_e = RD2_E;
`endif

  assign src_b = ALUSrcE ? Imm_Ext_E : write_data_e;

  alu #(
    .DATA_W(DATA_W)
  ) u_alu (
    .SrcA      (src_a),
    .SrcB      (src_b),
    .ALUControl(ALUControlE),
    .Result    (alu_result_e),
    .Zero      (zero_e)
  );

  assign PCSrcE    = BranchE & zero_e;
  assign PCTargetE = PCE + Imm_Ext_E;

  always_comb begin
    reg_write_d  = RegWriteE;
    mem_write_d  = MemWriteE;
    result_src_d = ResultSrcE;
    rd_d         = RD_E;
    alu_result_d = alu_result_e;
    write_data_d = write_data_e;
    pc_plus4_d   = PCPlus4E;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      reg_write_q  <= 1'b0;
      mem_write_q  <= 1'b0;
      result_src_q <= 1'b0;
      rd_q         <= '0;
      alu_result_q <= '0;
      write_data_q <= '0;
      pc_plus4_q   <= '0;
    end else begin
      reg_write_q  <= reg_write_d;
      mem_write_q  <= mem_write_d;
      result_src_q <= result_src_d;
      rd_q         <= rd_d;
      alu_result_q <= alu_result_d;
      write_data_q <= write_data_d;
      pc_plus4_q   <= pc_plus4_d;
    end
  end

  assign RegWriteM  = reg_write_q;
  assign MemWriteM  = mem_write_q;
  assign ResultSrcM = result_src_q;
  assign RD_M       = rd_q;
  assign ALUResultM = alu_result_q;
  assign WriteDataM = write_data_q;
  assign PCPlus4M   = pc_plus4_q;

endmodule
